// File: rtl/key_event_decoder_if.sv
// Keyboard-side signal bundle for key_event_decoder: scan code and press level in,
// decoded game actions and status out.
interface key_event_decoder_if;
    logic [7:0] keyCode;
    logic       press;
    logic       flap;
    logic       start;
    logic       restart;
    logic       paused;
    logic [7:0] active_key;
    logic       busy;

    modport master (
        output keyCode, press,
        input  flap, start, restart, paused, active_key, busy
    );

    modport slave (
        input  keyCode, press,
        output flap, start, restart, paused, active_key, busy
    );
endinterface

// File: rtl/key_event_decoder.sv
// Debounces scan-set-2 make codes into one-shot game actions with a post-release lockout.
// Optional macro KEY_AUTOREPEAT_EN adds a periodic flap repeat while Space is held.
module key_event_decoder #(
    parameter int unsigned STABLE_CYCLES   = 16,
    parameter int unsigned COOLDOWN_CYCLES = 50000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic              Clk,
    input  logic              reset,
    key_event_decoder_if.slave kbd
);
    localparam int          CNT_W     = 24;
    localparam logic [7:0]  KEY_SPACE = 8'h29;
    localparam logic [7:0]  KEY_ENTER = 8'h5A;
    localparam logic [7:0]  KEY_R     = 8'h2D;
    localparam logic [7:0]  KEY_P     = 8'h4D;
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, QUAL, HELD, COOLDOWN} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       k_q;
    logic             p_q;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       active_reg, active_next;
    logic             paused_reg, paused_next;
    logic [2:0]       pulse_reg, pulse_next;   // {restart, start, flap}
    logic             fire;
    logic             rpt_fire;
    logic             busy;

    function automatic logic is_known(input logic [7:0] code);
        return (code == KEY_SPACE) || (code == KEY_ENTER) ||
               (code == KEY_R)     || (code == KEY_P);
    endfunction

    // Input capture and all registered state
    always_ff @(posedge Clk) begin
        if (reset) begin
            k_q        <= 8'h00;
            p_q        <= 1'b0;
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            active_reg <= 8'h00;
            paused_reg <= 1'b0;
            pulse_reg  <= 3'b000;
        end else begin
            k_q        <= kbd.keyCode;
            p_q        <= kbd.press;
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            active_reg <= active_next;
            paused_reg <= paused_next;
            pulse_reg  <= pulse_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        active_next = active_reg;
        fire        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (p_q && is_known(k_q)) begin
                    state_next  = QUAL;
                    cnt_next    = '0;
                    active_next = k_q;
                end
            end
            QUAL: begin
                if (!p_q || (k_q != active_reg)) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    active_next = 8'h00;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!p_q) begin
                    state_next = COOLDOWN;
                    cnt_next   = '0;
                end else if ((k_q != active_reg) && is_known(k_q)) begin
                    // A new recognised key while held restarts qualification for it
                    state_next  = QUAL;
                    cnt_next    = '0;
                    active_next = k_q;
                end
            end
            COOLDOWN: begin
                if (cnt_reg == COOLDOWN_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    active_next = 8'h00;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                cnt_next    = '0;
                active_next = 8'h00;
            end
        endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rpt_reg, rpt_next;

    // Runs only while Space stays held; cleared on every HELD entry and exit
    always_comb begin
        rpt_next = '0;
        rpt_fire = 1'b0;
        if ((state_reg == HELD) && (state_next == HELD) && (active_reg == KEY_SPACE)) begin
            if (rpt_reg == REPEAT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_next = rpt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            rpt_reg <= '0;
        end else begin
            rpt_reg <= rpt_next;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        pulse_next  = 3'b000;
        paused_next = paused_reg;
        busy        = (state_reg != IDLE);
        if (fire) begin
            case (active_reg)
                KEY_SPACE: pulse_next[0] = 1'b1;
                KEY_ENTER: begin
                    pulse_next[1] = 1'b1;
                    paused_next   = 1'b0;
                end
                KEY_R: begin
                    pulse_next[2] = 1'b1;
                    paused_next   = 1'b0;
                end
                KEY_P:   paused_next = ~paused_reg;
                default: paused_next = paused_reg;
            endcase
        end
        if (rpt_fire) begin
            pulse_next[0] = 1'b1;
        end
    end

    assign kbd.flap       = pulse_reg[0];
    assign kbd.start      = pulse_reg[1];
    assign kbd.restart    = pulse_reg[2];
    assign kbd.paused     = paused_reg;
    assign kbd.active_key = active_reg;
    assign kbd.busy       = busy;
endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus queues expected pulse/paused events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_key_event_decoder;
    localparam int S = 4;
    localparam int C = 8;
    localparam int R = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_event_decoder_if kbd();

    key_event_decoder #(
        .STABLE_CYCLES(S),
        .COOLDOWN_CYCLES(C),
        .REPEAT_CYCLES(R)
    ) dut (
        .Clk(clk),
        .reset(reset),
        .kbd(kbd)
    );

    typedef struct {
        logic [2:0] pulses;   // {restart, start, flap}
        logic       paused;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  base;
    int  b2;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any pulse or paused change is a transaction to match against the queue
    logic       prev_paused = 1'b0;
    logic [2:0] got;
    ev_t        e;
    always @(negedge clk) begin
        got = {kbd.restart, kbd.start, kbd.flap};
        if (!reset && ((got != 3'b000) || (kbd.paused != prev_paused))) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got pulses=%b paused=%b required no event",
                         cyc, got, kbd.paused);
            end else begin
                e = exp_q.pop_front();
                if (e.pulses != got || e.paused != kbd.paused || e.cyc != cyc) begin
                    failures++;
                    $display("FAIL event got cyc=%0d pulses=%b paused=%b required cyc=%0d pulses=%b paused=%b",
                             cyc, got, kbd.paused, e.cyc, e.pulses, e.paused);
                end else begin
                    $display("event ok cyc=%0d pulses=%b paused=%b", cyc, got, kbd.paused);
                end
            end
        end
        prev_paused = kbd.paused;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h cyc=%0d", name, act, expv, cyc);
        end else begin
            $display("check ok %s = %0h cyc=%0d", name, act, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input logic [7:0] code, input logic pr);
        kbd.keyCode = code;
        kbd.press   = pr;
    endtask

    task automatic push(input logic [2:0] p, input logic pz, input int at);
        ev_t x;
        x.pulses = p;
        x.paused = pz;
        x.cyc    = at;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (kbd.busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (kbd.busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got busy=%b required 0 within %0d cycles", kbd.busy, limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        apply(8'h00, 1'b0);
        reset = 1'b1;
        step(3);
        chk("rst_flap", 32'(kbd.flap), 0);
        chk("rst_start", 32'(kbd.start), 0);
        chk("rst_restart", 32'(kbd.restart), 0);
        chk("rst_paused", 32'(kbd.paused), 0);
        chk("rst_busy", 32'(kbd.busy), 0);
        chk("rst_active", 32'(kbd.active_key), 0);
        reset = 1'b0;
        step(2);

        // Space held 20 cycles: flap at edge S+2, busy drops 9 edges after release is sampled
        apply(8'h29, 1'b1);
        base = cyc;
        push(3'b001, 1'b0, base + 6);
`ifdef KEY_AUTOREPEAT_EN
        push(3'b001, 1'b0, base + 16);
`endif
        step(10);
        chk("held_active", 32'(kbd.active_key), 32'h29);
        chk("held_busy", 32'(kbd.busy), 1);
        step(10);
        kbd.press = 1'b0;
        step(9);
        chk("cooldown_busy", 32'(kbd.busy), 1);
        step(1);
        chk("cooldown_done_busy", 32'(kbd.busy), 0);
        chk("cooldown_done_active", 32'(kbd.active_key), 0);
        step(2);

        // Short P press: no toggle
        apply(8'h4D, 1'b1);
        step(3);
        kbd.press = 1'b0;
        wait_idle(40);
        step(2);
        chk("short_p_paused", 32'(kbd.paused), 0);
        chk("short_p_busy", 32'(kbd.busy), 0);

        // Full P: paused 0->1, then again 1->0
        apply(8'h4D, 1'b1);
        base = cyc;
        push(3'b000, 1'b1, base + 6);
        step(6);
        kbd.press = 1'b0;
        wait_idle(40);
        step(2);
        chk("p1_paused", 32'(kbd.paused), 1);
        apply(8'h4D, 1'b1);
        base = cyc;
        push(3'b000, 1'b0, base + 6);
        step(6);
        kbd.press = 1'b0;
        wait_idle(40);
        step(2);

        // P qualified, then Enter while still held: start pulse clears paused same cycle
        apply(8'h4D, 1'b1);
        base = cyc;
        push(3'b000, 1'b1, base + 6);
        step(6);
        apply(8'h5A, 1'b1);
        b2 = cyc;
        push(3'b010, 1'b0, b2 + 6);
        step(6);
        chk("enter_active", 32'(kbd.active_key), 32'h5A);
        kbd.press = 1'b0;
        wait_idle(40);
        step(2);

        // R full press: restart pulse
        apply(8'h2D, 1'b1);
        base = cyc;
        push(3'b100, 1'b0, base + 6);
        step(6);
        kbd.press = 1'b0;
        wait_idle(40);
        step(2);

        // Unrecognised codes (including break prefix) never leave IDLE
        apply(8'h1C, 1'b1);
        step(10);
        chk("unk_busy_mid", 32'(kbd.busy), 0);
        step(10);
        chk("unk_busy_end", 32'(kbd.busy), 0);
        apply(8'hF0, 1'b1);
        step(10);
        chk("f0_busy", 32'(kbd.busy), 0);
        chk("f0_active", 32'(kbd.active_key), 0);
        apply(8'h29, 1'b0);
        step(5);
        chk("nopress_busy", 32'(kbd.busy), 0);

        // Space held 35 cycles: repeats only when the macro is built in
        apply(8'h29, 1'b1);
        base = cyc;
        push(3'b001, 1'b0, base + 6);
`ifdef KEY_AUTOREPEAT_EN
        push(3'b001, 1'b0, base + 16);
        push(3'b001, 1'b0, base + 26);
        push(3'b001, 1'b0, base + 36);
`endif
        step(35);
        kbd.press = 1'b0;
        wait_idle(40);
        step(2);

        // Reset at edge 4 of an R qualification drops the pending restart
        apply(8'h2D, 1'b1);
        step(3);
        reset = 1'b1;
        kbd.press = 1'b0;
        step(1);
        chk("midrst_flap", 32'(kbd.flap), 0);
        chk("midrst_start", 32'(kbd.start), 0);
        chk("midrst_restart", 32'(kbd.restart), 0);
        chk("midrst_paused", 32'(kbd.paused), 0);
        chk("midrst_busy", 32'(kbd.busy), 0);
        chk("midrst_active", 32'(kbd.active_key), 0);
        reset = 1'b0;
        step(20);
        chk("postrst_busy", 32'(kbd.busy), 0);

        step(5);
        chk("pending_events", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive cycles a code/press pair must be unchanged before acceptance; legal range 1..2^24-1.
REQ-002 Parameter COOLDOWN_CYCLES, default 50000: lockout length after key release; legal range 1..2^24-1.
REQ-003 Parameter REPEAT_CYCLES, default 5000000: held-flap repeat period; legal range 2..2^24-1.
REQ-004 Clk  in  1  system clock; all state changes on its rising edge; the block SHALL use this single clock only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 keyCode  in  8  scan-set-2 make code from the keyboard receiver.
REQ-007 press  in  1  key-held level from the keyboard receiver.
REQ-008 flap  out  1  one-cycle pulse for Space (0x29).
REQ-009 start  out  1  one-cycle pulse for Enter (0x5A).
REQ-010 restart  out  1  one-cycle pulse for R (0x2D).
REQ-011 paused  out  1  level, toggled by P (0x4D).
REQ-012 active_key  out  8  code currently qualified or held; 0x00 otherwise.
REQ-013 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-014 keyCode/press SHALL be registered once (k_q, p_q) every cycle; the FSM SHALL use only k_q/p_q.
REQ-015 Recognised codes are 0x29, 0x5A, 0x2D, 0x4D; all other codes, including 0xF0, SHALL produce no output and leave the FSM in IDLE.
REQ-016 States: IDLE, QUAL, HELD, COOLDOWN; one shared 24-bit counter cnt.
REQ-017 IDLE -> QUAL when p_q=1 and k_q recognised; cnt<=0, active_key<=k_q.
REQ-018 QUAL: if p_q=0 or k_q!=active_key -> IDLE, active_key<=0x00; else if cnt==STABLE_CYCLES-1 -> HELD with the key's action on the same edge; else cnt<=cnt+1.
REQ-019 Action latency: output pulse SHALL be high for exactly one cycle starting at rising edge STABLE_CYCLES+2, counting the first edge at which the stable input is presented as edge 1.
REQ-020 Actions: flap/start/restart pulse; P toggles paused; start and restart also clear paused to 0.
REQ-021 HELD: p_q=0 -> COOLDOWN, cnt<=0; p_q=1 with different recognised k_q -> QUAL for the new code, cnt<=0; p_q=1 with unrecognised different k_q -> ignored, remain HELD.
REQ-022 COOLDOWN: inputs ignored; -> IDLE, active_key<=0x00 when cnt==COOLDOWN_CYCLES-1, else cnt<=cnt+1.
REQ-023 At most one of flap/start/restart SHALL be high in any cycle.
REQ-024 Counters SHALL never wrap; comparisons are exact equality against parameter-1.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, cnt=0, repeat counter=0, k_q=0x00, p_q=0, all outputs 0, active_key=0x00, overriding any other event in that cycle.
REQ-026 Reset mid-QUAL or mid-HELD SHALL drop any pending action; no pulse after reset deasserts until a fresh full qualification.

Configuration
REQ-027 With KEY_AUTOREPEAT_EN defined: in HELD with active_key=0x29, a second counter SHALL emit a flap pulse every REPEAT_CYCLES cycles, first repeat REPEAT_CYCLES cycles after the initial pulse; counter cleared on HELD entry/exit.
REQ-028 Without KEY_AUTOREPEAT_EN: no repeat counter is built; holding any key yields exactly one action.

Verification (STABLE_CYCLES=4, COOLDOWN_CYCLES=8, REPEAT_CYCLES=10)
REQ-029 keyCode=0x29, press=1 held 20 cycles, then press=0 -> flap high exactly one cycle at edge 6; busy low again 9 cycles after release sampled.
REQ-030 keyCode=0x4D press for 3 cycles then press=0 -> no toggle, busy back to 0; repeat held 6 cycles -> paused 0->1; second full P after cooldown -> paused 1->0.
REQ-031 0x4D qualified (paused=1), then 0x5A qualified -> start pulse, paused=0 same cycle.
REQ-032 keyCode=0x1C press=1 for 20 cycles -> no outputs, busy stays 0.
REQ-033 0x29 held 35 cycles with KEY_AUTOREPEAT_EN -> flap pulses at edges 6, 16, 26, 36; without macro -> only edge 6.
REQ-034 reset asserted at edge 4 of a 0x2D qualification -> no restart pulse, all outputs 0 next cycle.
